// File: rtl/axi_rd_arb_pkg.sv
// Purpose: shared types and widths for the AXI read-request arbiter slice.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package axi_rd_arb_pkg;

  // Per-requester field widths
  localparam int ID_W    = 8;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int STR_W   = 3;
  localparam int NUM_W   = 8;
  localparam int IDX_W   = 2;   // grant index, covers up to 4 requesters

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Latched control fields of the granted request (address kept separately
  // because its width is a parameter of the top).
  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
    logic [STR_W-1:0]   str;
    logic [NUM_W-1:0]   num;
  } ar_ctl_t;

  // (idx + 1) mod n, for an index that is always below n
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/axi_rd_arb_rr_pick.sv
// Purpose: combinational round-robin picker, first set request at or after ptr.
// Latency: zero cycles (pure combinational).
// Backpressure: none; caller decides when the pick is consumed.
//
// Ports:
//   req  - request vector, one bit per requester
//   ptr  - highest-priority index for this pick
//   gnt  - one-hot winner (all zero when no request)
//   idx  - binary index of the winner (0 when no request)
//   any  - at least one request present
module axi_rd_arb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int pos;

  // Walk offsets 0..N-1 from ptr; the first requester hit wins. The inner
  // loop keeps every req[] select at a constant index.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int off = 0; off < N; off++) begin
      pos = (int'(ptr) + off) % N;
      for (int i = 0; i < N; i++) begin
        if (!any && req[i] && (pos == i)) begin
          any    = 1'b1;
          gnt[i] = 1'b1;
          idx    = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/axi_rd_arb.sv
// Purpose: round-robin share of one AXI read interface among NREQ requesters.
// Latency: grant same cycle as arvld (IDLE), downstream arvld 1 cycle later; responses pass through with 0 cycles.
// Backpressure: downstream arrdy holds ADDR; granted requester's rrdy drives lsu_axi_rrdy; others' rrdy ignored.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   req_ar*            - packed per-requester read requests (requester i in slice i)
//   req_arrdy          - one-hot accept, only in IDLE
//   req_rvld/req_r*    - one-hot response valid plus shared response fields
//   req_rrdy           - per-requester response ready
//   lsu_axi_ar*        - request to the AXI read interface block
//   axi_lsu_*          - response from the AXI read interface block
//   lsu_axi_rrdy       - response ready toward the AXI read interface block
//   busy, grant_idx    - FSM not idle, index of current/last grant
//   rresp_err          - sticky error flag for any forwarded non-OKAY beat
module axi_rd_arb
  import axi_rd_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 10,
  parameter int DW   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  // requester side
  input  logic [NREQ-1:0]         req_arvld,
  input  logic [NREQ*ID_W-1:0]    req_arid,
  input  logic [NREQ*AW-1:0]      req_araddr,
  input  logic [NREQ*LEN_W-1:0]   req_arlen,
  input  logic [NREQ*SIZE_W-1:0]  req_arsize,
  input  logic [NREQ*BURST_W-1:0] req_arburst,
  input  logic [NREQ*STR_W-1:0]   req_arstr,
  input  logic [NREQ*NUM_W-1:0]   req_arnum,
  output logic [NREQ-1:0]         req_arrdy,
  output logic [NREQ-1:0]         req_rvld,
  output logic [ID_W-1:0]         req_rid,
  output logic [DW-1:0]           req_rdata,
  output logic [1:0]              req_rresp,
  output logic                    req_rlast,
  input  logic [NREQ-1:0]         req_rrdy,
  // AXI read interface side
  output logic                    lsu_axi_arvld,
  output logic [ID_W-1:0]         lsu_axi_arid,
  output logic [AW-1:0]           lsu_axi_araddr,
  output logic [LEN_W-1:0]        lsu_axi_arlen,
  output logic [SIZE_W-1:0]       lsu_axi_arsize,
  output logic [BURST_W-1:0]      lsu_axi_arburst,
  output logic [STR_W-1:0]        lsu_axi_arstr,
  output logic [NUM_W-1:0]        lsu_axi_arnum,
  input  logic                    axi_lsu_arrdy,
  input  logic                    axi_lsu_rvld,
  input  logic [ID_W-1:0]         axi_lsu_rid,
  input  logic [DW-1:0]           axi_lsu_rdata,
  input  logic [1:0]              axi_lsu_rresp,
  input  logic                    axi_lsu_rlast,
  output logic                    lsu_axi_rrdy,
  // status
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    rresp_err
);

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [NUM_W-1:0]  bursts_left;
  ar_ctl_t           ar_q;
  logic [AW-1:0]     addr_q;

  logic [NREQ-1:0]   win_gnt;
  logic [IDX_W-1:0]  win_idx;
  logic              win_any;
  ar_ctl_t           win_ctl;
  logic [AW-1:0]     win_addr;
  logic              beat;

  axi_rd_arb_rr_pick #(
    .N  (NREQ),
    .IW (IDX_W)
  ) u_pick (
    .req (req_arvld),
    .ptr (rr_ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // One-hot AND-OR mux of the winner's request fields
  always_comb begin
    win_ctl  = '0;
    win_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_gnt[i]) begin
        win_ctl.id    = req_arid[i*ID_W +: ID_W];
        win_ctl.len   = req_arlen[i*LEN_W +: LEN_W];
        win_ctl.size  = req_arsize[i*SIZE_W +: SIZE_W];
        win_ctl.burst = req_arburst[i*BURST_W +: BURST_W];
        win_ctl.str   = req_arstr[i*STR_W +: STR_W];
        win_ctl.num   = req_arnum[i*NUM_W +: NUM_W];
        win_addr      = req_araddr[i*AW +: AW];
      end
    end
  end

  // Accept is masked during reset so a requester never sees a handshake
  // that the reset then throws away.
  assign req_arrdy = (state == ST_IDLE && !rst) ? win_gnt : '0;

  // Response routing: only the granted requester sees valid, only its
  // ready reaches downstream. Outside DATA stray responses stall.
  always_comb begin
    req_rvld     = '0;
    lsu_axi_rrdy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (state == ST_DATA && grant_idx == IDX_W'(i)) begin
        req_rvld[i]  = axi_lsu_rvld;
        lsu_axi_rrdy = req_rrdy[i];
      end
    end
  end

  assign beat = axi_lsu_rvld & lsu_axi_rrdy;

  // Shared response fields, qualified by req_rvld
  assign req_rid   = axi_lsu_rid;
  assign req_rdata = axi_lsu_rdata;
  assign req_rresp = axi_lsu_rresp;
  assign req_rlast = axi_lsu_rlast;

  // Downstream request fields come straight from the latch
  assign lsu_axi_arid    = ar_q.id;
  assign lsu_axi_araddr  = addr_q;
  assign lsu_axi_arlen   = ar_q.len;
  assign lsu_axi_arsize  = ar_q.size;
  assign lsu_axi_arburst = ar_q.burst;
  assign lsu_axi_arstr   = ar_q.str;
  assign lsu_axi_arnum   = ar_q.num;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      grant_idx     <= '0;
      bursts_left   <= '0;
      rresp_err     <= 1'b0;
      ar_q          <= '0;
      addr_q        <= '0;
      lsu_axi_arvld <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_any) begin
            ar_q          <= win_ctl;
            addr_q        <= win_addr;
            grant_idx     <= win_idx;
            lsu_axi_arvld <= 1'b1;
            state         <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (axi_lsu_arrdy) begin
            lsu_axi_arvld <= 1'b0;
            // arnum of zero still means one burst
            bursts_left   <= (ar_q.num == '0) ? NUM_W'(1) : ar_q.num;
            state         <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat && axi_lsu_rlast) begin
            if (bursts_left != '0) begin
              bursts_left <= bursts_left - 1'b1;
            end
            if (bursts_left == NUM_W'(1)) begin
              rr_ptr <= wrap_inc(grant_idx, NREQ);
              state  <= ST_IDLE;
            end
          end
        end
        default: begin
          state         <= ST_IDLE;
          lsu_axi_arvld <= 1'b0;
        end
      endcase

      if (beat && axi_lsu_rresp != AXI_RESP_OKAY) begin
        rresp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arb.sv
module tb_axi_rd_arb;
  localparam int NREQ = 2;
  localparam int AW   = 10;
  localparam int DW   = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_arvld;
  logic [NREQ*8-1:0]   req_arid;
  logic [NREQ*AW-1:0]  req_araddr;
  logic [NREQ*8-1:0]   req_arlen;
  logic [NREQ*3-1:0]   req_arsize;
  logic [NREQ*2-1:0]   req_arburst;
  logic [NREQ*3-1:0]   req_arstr;
  logic [NREQ*8-1:0]   req_arnum;
  logic [NREQ-1:0]     req_arrdy;
  logic [NREQ-1:0]     req_rvld;
  logic [7:0]          req_rid;
  logic [DW-1:0]       req_rdata;
  logic [1:0]          req_rresp;
  logic                req_rlast;
  logic [NREQ-1:0]     req_rrdy;
  logic                lsu_axi_arvld;
  logic [7:0]          lsu_axi_arid;
  logic [AW-1:0]       lsu_axi_araddr;
  logic [7:0]          lsu_axi_arlen;
  logic [2:0]          lsu_axi_arsize;
  logic [1:0]          lsu_axi_arburst;
  logic [2:0]          lsu_axi_arstr;
  logic [7:0]          lsu_axi_arnum;
  logic                axi_lsu_arrdy;
  logic                axi_lsu_rvld;
  logic [7:0]          axi_lsu_rid;
  logic [DW-1:0]       axi_lsu_rdata;
  logic [1:0]          axi_lsu_rresp;
  logic                axi_lsu_rlast;
  logic                lsu_axi_rrdy;
  logic                busy;
  logic [1:0]          grant_idx;
  logic                rresp_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_rd_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_arvld(req_arvld), .req_arid(req_arid), .req_araddr(req_araddr),
    .req_arlen(req_arlen), .req_arsize(req_arsize), .req_arburst(req_arburst),
    .req_arstr(req_arstr), .req_arnum(req_arnum), .req_arrdy(req_arrdy),
    .req_rvld(req_rvld), .req_rid(req_rid), .req_rdata(req_rdata),
    .req_rresp(req_rresp), .req_rlast(req_rlast), .req_rrdy(req_rrdy),
    .lsu_axi_arvld(lsu_axi_arvld), .lsu_axi_arid(lsu_axi_arid),
    .lsu_axi_araddr(lsu_axi_araddr), .lsu_axi_arlen(lsu_axi_arlen),
    .lsu_axi_arsize(lsu_axi_arsize), .lsu_axi_arburst(lsu_axi_arburst),
    .lsu_axi_arstr(lsu_axi_arstr), .lsu_axi_arnum(lsu_axi_arnum),
    .axi_lsu_arrdy(axi_lsu_arrdy), .axi_lsu_rvld(axi_lsu_rvld),
    .axi_lsu_rid(axi_lsu_rid), .axi_lsu_rdata(axi_lsu_rdata),
    .axi_lsu_rresp(axi_lsu_rresp), .axi_lsu_rlast(axi_lsu_rlast),
    .lsu_axi_rrdy(lsu_axi_rrdy),
    .busy(busy), .grant_idx(grant_idx), .rresp_err(rresp_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [63:0] onehot(input int g);
    return 64'd1 << g;
  endfunction

  task automatic set_req(input int i, input logic [7:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [7:0] num);
    req_arid[i*8 +: 8]    = id;
    req_araddr[i*AW +: AW] = addr;
    req_arlen[i*8 +: 8]   = len;
    req_arsize[i*3 +: 3]  = 3'd3;
    req_arburst[i*2 +: 2] = 2'd1;
    req_arstr[i*3 +: 3]   = 3'd0;
    req_arnum[i*8 +: 8]   = num;
  endtask

  // One full transaction for requester g made of nb single-beat bursts.
  task automatic txn(input int g, input int nb, input logic [AW-1:0] addr);
    settle();
    chk("txn_arrdy", req_arrdy, onehot(g));
    tick();
    chk("txn_arvld", lsu_axi_arvld, 1);
    chk("txn_araddr", lsu_axi_araddr, addr);
    chk("txn_gidx", grant_idx, g);
    chk("txn_rrdy_addr", lsu_axi_rrdy, 0);
    axi_lsu_arrdy = 1'b1;
    tick();
    axi_lsu_arrdy = 1'b0;
    for (int b = 0; b < nb; b++) begin
      axi_lsu_rvld  = 1'b1;
      axi_lsu_rlast = 1'b1;
      axi_lsu_rdata = 64'(g * 16 + b);
      settle();
      chk("txn_rvld", req_rvld, onehot(g));
      chk("txn_rdata", req_rdata, 64'(g * 16 + b));
      tick();
      axi_lsu_rvld = 1'b0;
      settle();
      chk("txn_busy", busy, (b < nb - 1) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_arvld = '0; req_arid = '0; req_araddr = '0; req_arlen = '0;
    req_arsize = '0; req_arburst = '0; req_arstr = '0; req_arnum = '0;
    req_rrdy = '0;
    axi_lsu_arrdy = 1'b0; axi_lsu_rvld = 1'b0; axi_lsu_rid = '0;
    axi_lsu_rdata = '0; axi_lsu_rresp = '0; axi_lsu_rlast = 1'b0;
    tick(); tick();
    rst = 1'b0;
    settle();
    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_gidx", grant_idx, 0);
    chk("rst_err", rresp_err, 0);
    chk("rst_arvld", lsu_axi_arvld, 0);
    chk("rst_rrdy", lsu_axi_rrdy, 0);
    chk("rst_arrdy", req_arrdy, 0);
    chk("rst_rvld", req_rvld, 0);
    chk("rst_araddr", lsu_axi_araddr, 0);

    // 1: single request, one burst of 4 beats
    set_req(0, 8'h11, 10'h040, 8'd3, 8'd1);
    req_arvld = 2'b01;
    req_rrdy  = 2'b01;
    settle();
    chk("t1_arrdy", req_arrdy, 2'b01);
    tick();
    req_arvld = 2'b00;
    settle();
    chk("t1_arvld", lsu_axi_arvld, 1);
    chk("t1_araddr", lsu_axi_araddr, 10'h040);
    chk("t1_arid", lsu_axi_arid, 8'h11);
    chk("t1_arlen", lsu_axi_arlen, 3);
    chk("t1_arnum", lsu_axi_arnum, 1);
    chk("t1_arrdy_addr", req_arrdy, 0);
    chk("t1_busy", busy, 1);
    axi_lsu_arrdy = 1'b1;
    tick();
    axi_lsu_arrdy = 1'b0;
    settle();
    chk("t1_arvld_drop", lsu_axi_arvld, 0);
    for (int k = 0; k < 4; k++) begin
      axi_lsu_rvld  = 1'b1;
      axi_lsu_rdata = 64'h100 + 64'(k);
      axi_lsu_rlast = (k == 3);
      settle();
      chk("t1_rvld", req_rvld, 2'b01);
      chk("t1_rdata", req_rdata, 64'h100 + 64'(k));
      chk("t1_rrdy", lsu_axi_rrdy, 1);
      tick();
      if (k < 3) chk("t1_busy_mid", busy, 1);
    end
    axi_lsu_rvld = 1'b0;
    settle();
    chk("t1_done", busy, 0);

    // 2+3: contention from reset; req0 has 3 bursts, req1 arnum=0 means 1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 8'h20, 10'h100, 8'd0, 8'd3);
    set_req(1, 8'h21, 10'h200, 8'd0, 8'd0);
    req_rrdy  = 2'b11;
    req_arvld = 2'b11;
    txn(0, 3, 10'h100);
    txn(1, 1, 10'h200);
    txn(0, 3, 10'h100);
    req_arvld = 2'b00;

    // 4: backpressure from granted requester; req1's ready is ignored
    set_req(0, 8'h30, 10'h0A0, 8'd0, 8'd1);
    req_arvld = 2'b01;
    settle();
    chk("t4_arrdy", req_arrdy, 2'b01);
    tick();
    req_arvld = 2'b00;
    axi_lsu_arrdy = 1'b1;
    tick();
    axi_lsu_arrdy = 1'b0;
    req_rrdy      = 2'b10;
    axi_lsu_rvld  = 1'b1;
    axi_lsu_rlast = 1'b1;
    axi_lsu_rdata = 64'hDEAD;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("t4_rrdy_held", lsu_axi_rrdy, 0);
      chk("t4_rvld_held", req_rvld, 2'b01);
      tick();
      chk("t4_busy_held", busy, 1);
    end
    req_rrdy = 2'b11;
    settle();
    chk("t4_rrdy_go", lsu_axi_rrdy, 1);
    chk("t4_rdata", req_rdata, 64'hDEAD);
    tick();
    axi_lsu_rvld = 1'b0;
    settle();
    chk("t4_done", busy, 0);

    // 5: stray response in IDLE is held off; error beat sets sticky flag
    axi_lsu_rvld  = 1'b1;
    axi_lsu_rresp = 2'b10;
    settle();
    chk("t5_stray_rrdy", lsu_axi_rrdy, 0);
    chk("t5_stray_rvld", req_rvld, 0);
    tick();
    chk("t5_err_clear", rresp_err, 0);
    set_req(1, 8'h51, 10'h155, 8'd0, 8'd1);
    req_arvld = 2'b10;
    txn(1, 1, 10'h155);
    req_arvld = 2'b00;
    axi_lsu_rresp = 2'b00;
    chk("t5_err_set", rresp_err, 1);
    tick(); tick();
    chk("t5_err_sticky", rresp_err, 1);

    // 6: reset mid-DATA; rr_ptr is 1 before reset, must return to 0
    set_req(0, 8'h60, 10'h060, 8'd0, 8'd1);
    req_arvld = 2'b01;
    txn(0, 1, 10'h060);
    set_req(1, 8'h61, 10'h061, 8'd0, 8'd3);
    req_arvld = 2'b10;
    settle();
    chk("t6_arrdy", req_arrdy, 2'b10);
    tick();
    req_arvld = 2'b00;
    axi_lsu_arrdy = 1'b1;
    tick();
    axi_lsu_arrdy = 1'b0;
    axi_lsu_rvld  = 1'b1;
    axi_lsu_rlast = 1'b1;
    tick();
    settle();
    chk("t6_busy_pre", busy, 1);
    chk("t6_rvld_pre", req_rvld, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("t6_busy", busy, 0);
    chk("t6_rvld", req_rvld, 0);
    chk("t6_arvld", lsu_axi_arvld, 0);
    chk("t6_rrdy", lsu_axi_rrdy, 0);
    chk("t6_gidx", grant_idx, 0);
    chk("t6_err", rresp_err, 0);
    axi_lsu_rvld = 1'b0;
    req_arvld = 2'b11;
    settle();
    chk("t6_ptr", req_arrdy, 2'b01);
    req_arvld = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
